// File: rtl/sort4_pkg.sv
// Shared definitions for the 4-element, 4-bit bubble sorter (sort4_ctrl).
package sort4_pkg;

    localparam int ELEM_W = 4;
    localparam int ELEM_N = 4;
    localparam logic [1:0] PASS_MAX = 2'd2;
    localparam logic [1:0] IDX_LAST = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [ELEM_N-1:0][ELEM_W-1:0] elems_t;

endpackage

// File: rtl/sort4_ctrl_cmp.sv
// Unsigned N-bit magnitude comparator: greater-than and equal flags.
module nbit_comparator #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         agb,
    output logic         aeb
);

    assign agb = (a > b);
    assign aeb = (a == b);

endmodule

// File: rtl/sort4_ctrl.sv
// Sequential bubble sort of four 4-bit elements using a single shared comparator.
// Optional SORT4_SWAPCNT_EN adds a swap_cnt output counting swaps of the current sort.
module sort4_ctrl
    import sort4_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] din,
    output logic        busy,
    output logic        done,
    output logic [15:0] dout
`ifdef SORT4_SWAPCNT_EN
    ,
    output logic [2:0]  swap_cnt
`endif
);

    state_t     state_q, state_d;
    elems_t     elem_q, elem_nx;
    logic [1:0] pass_q;
    logic [1:0] idx_q;
    logic       swapped_q;
    logic [ELEM_W-1:0] cmp_a, cmp_b;
    logic       agb, aeb;
    logic       pass_end;

    assign cmp_a = elem_q[idx_q];
    assign cmp_b = elem_q[idx_q + 2'd1];

    nbit_comparator #(.N(ELEM_W)) u_cmp (
        .a   (cmp_a),
        .b   (cmp_b),
        .agb (agb),
        .aeb (aeb)
    );

    // Equal pairs stay in place (agb is false when aeb), which keeps the sort stable.
    always_comb begin
        elem_nx = elem_q;
        if (agb && !aeb) begin
            elem_nx[idx_q]        = cmp_b;
            elem_nx[idx_q + 2'd1] = cmp_a;
        end
    end

    // Last compare of a pass finishes the sort if that pass was clean or the pass limit is hit.
    assign pass_end = (idx_q == IDX_LAST) &&
                      (!(swapped_q || agb) || (pass_q == PASS_MAX));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CMP;
            CMP:     if (pass_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            elem_q    <= '0;
            pass_q    <= '0;
            idx_q     <= '0;
            swapped_q <= 1'b0;
            dout      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        elem_q    <= din;
                        pass_q    <= '0;
                        idx_q     <= '0;
                        swapped_q <= 1'b0;
                    end
                end
                CMP: begin
                    elem_q <= elem_nx;
                    if (idx_q == IDX_LAST) begin
                        if (pass_end) begin
                            dout <= elem_nx;
                        end else begin
                            pass_q    <= pass_q + 2'd1;
                            idx_q     <= '0;
                            swapped_q <= 1'b0;
                        end
                    end else begin
                        idx_q <= idx_q + 2'd1;
                        if (agb) swapped_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q == CMP);
    assign done = (state_q == DONE);

`ifdef SORT4_SWAPCNT_EN
    localparam logic [2:0] SWAP_MAX = 3'd6;

    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= SWAP_MAX) ? SWAP_MAX : v + 3'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_cnt <= '0;
        end else if (state_q == IDLE && start) begin
            swap_cnt <= '0;
        end else if (state_q == CMP && agb) begin
            swap_cnt <= sat_inc(swap_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_sort4_ctrl.sv
// Bench for sort4_ctrl: directed table, randomized sorts against a reference model,
// and hand-written sequences for held start, back-to-back and mid-sort reset.
module tb_sort4_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
`ifdef SORT4_SWAPCNT_EN
    logic [2:0]  swap_cnt;
`endif

    int errors = 0;
    int checks = 0;

    sort4_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout)
`ifdef SORT4_SWAPCNT_EN
        ,
        .swap_cnt (swap_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] din;
        logic [15:0] exp_dout;
        int          exp_lat;
        int          exp_swaps;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: sorted values, swap count = number of inversions, and passes run =
    // (largest leftward displacement of any element) + 1, capped at three.
    task automatic model(input logic [15:0] d, output logic [15:0] s,
                         output int lat, output int sw);
        int e[4];
        int tmp, maxl, l, passes;
        for (int k = 0; k < 4; k++) e[k] = int'(d[4*k +: 4]);
        sw = 0;
        maxl = 0;
        for (int j = 0; j < 4; j++) begin
            l = 0;
            for (int i = 0; i < j; i++) if (e[i] > e[j]) l++;
            sw += l;
            if (l > maxl) maxl = l;
        end
        passes = (maxl + 1 > 3) ? 3 : maxl + 1;
        lat = 1 + 3 * passes;
        for (int i = 1; i < 4; i++)
            for (int j = i; j > 0 && e[j-1] > e[j]; j--) begin
                tmp = e[j]; e[j] = e[j-1]; e[j-1] = tmp;
            end
        s = '0;
        for (int k = 0; k < 4; k++) s[4*k +: 4] = 4'(e[k]);
    endtask

    task automatic run_sort(input string nm, input logic [15:0] d, input logic [15:0] xd,
                            input int xlat, input int xsw);
        int lat;
        int busy_ok;
        @(negedge clk);
        din = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        din = 16'($urandom);
        lat = 0;
        busy_ok = 1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                break;
            end
            if (!busy) busy_ok = 0;
        end
        chk({nm, ".latency"}, lat, xlat);
        chk({nm, ".busy_during_cmp"}, busy_ok, 1);
        chk({nm, ".busy_at_done"}, int'(busy), 0);
        chk({nm, ".dout"}, int'(dout), int'(xd));
`ifdef SORT4_SWAPCNT_EN
        chk({nm, ".swap_cnt"}, int'(swap_cnt), xsw);
`else
        if (xsw < 0) chk({nm, ".swaps_nonneg"}, xsw, 0);
`endif
        @(negedge clk);
        chk({nm, ".done_single"}, int'(done), 0);
        chk({nm, ".dout_hold"}, int'(dout), int'(xd));
    endtask

    vec_t        vecs[4];
    logic [15:0] md;
    logic [15:0] rd;
    int          ml, ms;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        din   = '0;

        vecs[0] = '{"sorted",   16'h4321, 16'h4321, 4,  0};
        vecs[1] = '{"reverse",  16'h2479, 16'h9742, 10, 6};
        vecs[2] = '{"dups",     16'h5055, 16'h5550, 10, 2};
        vecs[3] = '{"extremes", 16'h0F0F, 16'hFF00, 10, 3};

        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++)
            run_sort(vecs[v].name, vecs[v].din, vecs[v].exp_dout,
                     vecs[v].exp_lat, vecs[v].exp_swaps);

        for (int r = 0; r < 40; r++) begin
            rd = 16'($urandom);
            model(rd, md, ml, ms);
            run_sort($sformatf("rand%0d", r), rd, md, ml, ms);
        end

        // start held high, din cleared mid-sort: one result, then a fresh sort from IDLE
        @(negedge clk);
        din = 16'h2479;
        start = 1'b1;
        @(posedge clk);
        #1;
        din = 16'h0000;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            chk($sformatf("held.done_c%0d", c), int'(done), int'(c == 10 || c == 15));
            chk($sformatf("held.busy_c%0d", c), int'(busy),
                int'((c >= 1 && c <= 9) || (c >= 12 && c <= 14)));
            if (c == 10) begin
                chk("held.dout_first", int'(dout), 16'h9742);
`ifdef SORT4_SWAPCNT_EN
                chk("held.swap_cnt_first", int'(swap_cnt), 6);
`endif
            end
            if (c == 15) chk("held.dout_second", int'(dout), 0);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);

        // reset in the middle of a reverse sort
        din = 16'h2479;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.dout", int'(dout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("midrst.idle_done_c%0d", c), int'(done), 0);
            chk($sformatf("midrst.idle_busy_c%0d", c), int'(busy), 0);
        end
        model(16'h0213, md, ml, ms);
        run_sort("after_rst", 16'h0213, 16'h3210, ml, ms);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
